memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Multi-client, multi-bank front end for the iCE40UP single-port SPRAM. It lets the CPU port and CHANNELS read-only requesters (graphics, DMA, audio fetch) share one access per clock, using a valid/ready handshake and round-robin arbitration. CPU writes support byte masking. It replaces the single-bank, single-GFX-port memory block and sits between the CPU/peripheral bus and the SB_SPRAM256KA primitives.

## Interface
Parameters:
- BITS, 16: data width; fixed at 16 because of the SPRAM primitive.
- ADDRESS_BITS, 15: word address width, legal 14..16. BANKS = 2^(ADDRESS_BITS-14) SPRAM instances.
- CHANNELS, 2: number of read-only requester channels, legal 1..4.
- CPU_PRIORITY, 1: 1 = CPU has fixed priority over channels; 0 = CPU is slot 0 in the round-robin.

Ports:
- CLK  in  1  system clock; all state is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- CPU_ADDRESS  in  ADDRESS_BITS  CPU word address.
- CPU_DATA_IN  in  BITS  CPU write data.
- CPU_WR  in  1  1 = write, 0 = read; qualified by CPU_VALID.
- CPU_BYTE_EN  in  2  write byte enables; bit0 = [7:0], bit1 = [15:8].
- CPU_VALID  in  1  CPU request pending.
- CPU_READY  out  1  one-cycle pulse: CPU access complete, and CPU_DATA_OUT is valid for reads.
- CPU_DATA_OUT  out  BITS  CPU read data.
- CH_ADDRESS  in  CHANNELS*ADDRESS_BITS  channel word addresses; channel i occupies bits [i*ADDRESS_BITS +: ADDRESS_BITS].
- CH_VALID  in  CHANNELS  channel read request pending.
- CH_READY  out  CHANNELS  one-cycle pulse per channel: read complete.
- CH_DATA_OUT  out  BITS  shared channel read data; valid only in the cycle its CH_READY bit is high.

## Operation
- Requester rules: a requester asserts VALID and holds ADDRESS, WR, DATA_IN and BYTE_EN stable until it sees READY. In the READY cycle it may drop VALID or present a new request.
- Eligibility: a requester is eligible when its VALID is high and it was not granted in the previous cycle. This masking prevents a second acceptance of a request that is still held during its READY cycle.
- Grant, CPU_PRIORITY=1: an eligible CPU always wins. Otherwise the first eligible channel at or after rr_ptr, in modulo-CHANNELS order, wins.
- Grant, CPU_PRIORITY=0: round-robin over CHANNELS+1 slots, with the CPU as slot 0.
- Pointer update: after a grant, rr_ptr moves to granted index + 1, modulo the slot count. It is unchanged on idle cycles or CPU-priority grants.
- At most one grant per cycle. When nothing is granted, no SPRAM is accessed: WREN=0 and the address lines hold.
- Banking: bank = addr[ADDRESS_BITS-1:14]; addr[13:0] goes to every bank's address input. CHIPSELECT is asserted only on the selected bank.
- Write path: WREN is driven only on the selected bank and only for a granted CPU write. MASKWREN = {BYTE_EN[1],BYTE_EN[1],BYTE_EN[0],BYTE_EN[0]}.
- BYTE_EN = 2'b00 with CPU_WR=1: handshake completes with no memory change.
- Read return: the grant owner and bank are registered. Next cycle the registered bank's DATAOUT is muxed to CPU_DATA_OUT or CH_DATA_OUT, and the matching READY bit pulses.
- CPU writes also return a CPU_READY pulse; CPU_DATA_OUT in that cycle is undefined.
- Power pins: STANDBY=0, SLEEP=0, POWEROFF=1 on all banks.

## Timing
- Reset: CPU_READY=0, CH_READY=0, rr_ptr=0, grant register cleared. Data outputs are undefined until the first READY.
- Latency: request accepted in cycle N means READY and data in cycle N+1. Best-case single-requester throughput is one access every 2 cycles; aggregate throughput is one access per cycle.
- Fairness bound with CPU_PRIORITY=1: the CPU can take at most every other cycle. A channel waiting with all others valid is granted within 2*CHANNELS cycles.
- Simultaneous CPU write and channel read of the same address: the CPU wins. The channel is granted later and reads the new data.
- Address wrap: only ADDRESS_BITS bits are decoded; no out-of-range handling is needed.
- RST asserted mid-access: the pending READY is never issued and the requester must re-request. A write granted in the cycle RST rises may or may not land. SPRAM contents are not cleared.
- READY outputs are registered; there is no combinational path from any VALID to any READY.

## Test plan
- CPU write 0x1234 to 0x0005 (BYTE_EN=11), then read 0x0005 -> CPU_READY one cycle after each grant; read returns 0x1234.
- Write 0xAB00 to 0x0005 with BYTE_EN=10 over 0x1234 -> read returns 0xAB34.
- With ADDRESS_BITS=15, write 0x1111 to 0x0010 and 0x2222 to 0x4010 -> reads return 0x1111 and 0x2222 respectively, showing no bank aliasing.
- CHANNELS=2, CH_VALID=11 held continuously, CPU idle -> grants alternate ch0, ch1, ch0…; each CH_READY pulses every other cycle; each read returns its own address's data.
- CPU_PRIORITY=1, CPU_VALID and both channels held continuously -> CPU is granted on alternate cycles, and channels alternate in the gaps. No channel waits more than 4 cycles.
- RST pulsed in the cycle after a CPU read grant -> no CPU_READY appears. After reset all READY bits are 0; a reissued read completes normally and memory contents are intact.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Request/response bundle between the memory arbiter and its requesters.
// One CPU port (read/write with byte masking) plus CHANNELS read-only ports.
interface memory_arbiter_if #(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 15,
    parameter int CHANNELS     = 2
);
    logic [ADDRESS_BITS-1:0]          CPU_ADDRESS;
    logic [BITS-1:0]                  CPU_DATA_IN;
    logic                             CPU_WR;
    logic [1:0]                       CPU_BYTE_EN;
    logic                             CPU_VALID;
    logic                             CPU_READY;
    logic [BITS-1:0]                  CPU_DATA_OUT;
    logic [CHANNELS*ADDRESS_BITS-1:0] CH_ADDRESS;
    logic [CHANNELS-1:0]              CH_VALID;
    logic [CHANNELS-1:0]              CH_READY;
    logic [BITS-1:0]                  CH_DATA_OUT;

    // Requester side
    modport master (
        output CPU_ADDRESS, CPU_DATA_IN, CPU_WR, CPU_BYTE_EN, CPU_VALID,
        output CH_ADDRESS, CH_VALID,
        input  CPU_READY, CPU_DATA_OUT, CH_READY, CH_DATA_OUT
    );

    // Arbiter side
    modport slave (
        input  CPU_ADDRESS, CPU_DATA_IN, CPU_WR, CPU_BYTE_EN, CPU_VALID,
        input  CH_ADDRESS, CH_VALID,
        output CPU_READY, CPU_DATA_OUT, CH_READY, CH_DATA_OUT
    );
endinterface

// File: rtl/memory_arbiter.sv
// Multi-client, multi-bank SPRAM front end. One access per clock is granted
// to either the CPU or one of CHANNELS read-only requesters; the result comes
// back one cycle later with a single-cycle READY pulse. Each bank is a
// behavioural model of an SB_SPRAM256KA (16K x 16, nibble write mask,
// registered read data); the real primitive ties STANDBY=0, SLEEP=0,
// POWEROFF=1, which the model implies by being always powered.
module memory_arbiter #(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 15,
    parameter int CHANNELS     = 2,
    parameter int CPU_PRIORITY = 1
) (
    input logic CLK,
    input logic RST,
    memory_arbiter_if.slave bus
);
    localparam int BANKS  = 1 << (ADDRESS_BITS - 14);
    localparam int BANK_W = (ADDRESS_BITS > 14) ? (ADDRESS_BITS - 14) : 1;
    localparam int NSLOTS = CHANNELS + 1;
    localparam int PTR_W  = $clog2(NSLOTS);

    // Slot 0 is the CPU, slot i+1 is channel i.
    logic                    r_cpuReady;
    logic [CHANNELS-1:0]     r_chReady;
    logic [PTR_W-1:0]        r_rrPtr;
    logic [BANK_W-1:0]       r_bank;
    logic [ADDRESS_BITS-1:0] r_heldAddr;

    logic                    w_cpuElig;
    logic [CHANNELS-1:0]     w_chElig;
    logic [NSLOTS-1:0]       w_slotElig;
    logic                    w_grantValid;
    logic [PTR_W-1:0]        w_grantSlot;
    logic [PTR_W-1:0]        w_nextPtr;
    logic                    w_grantCpu;
    logic [CHANNELS-1:0]     w_chGrant;
    logic [ADDRESS_BITS-1:0] w_reqAddr;
    logic [ADDRESS_BITS-1:0] w_memAddr;
    logic [BANK_W-1:0]       w_bank;
    logic                    w_write;
    logic [3:0]              w_maskWren;
    logic [BITS-1:0]         w_bankOut [BANKS];

    // A requester granted last cycle is still holding VALID during its READY
    // cycle, so it is masked out to avoid accepting the same request twice.
    assign w_cpuElig  = bus.CPU_VALID & ~r_cpuReady;
    assign w_chElig   = bus.CH_VALID & ~r_chReady;
    assign w_slotElig = {w_chElig, w_cpuElig};

    // Pick at most one winner and compute where the round-robin resumes.
    always_comb begin
        int idx;
        idx          = 0;
        w_grantValid = 1'b0;
        w_grantSlot  = '0;
        w_nextPtr    = r_rrPtr;
        if (CPU_PRIORITY != 0) begin
            if (w_cpuElig) begin
                w_grantValid = 1'b1;
                w_grantSlot  = '0;
            end else begin
                for (int k = 0; k < CHANNELS; k++) begin
                    idx = int'(r_rrPtr) + k;
                    if (idx >= CHANNELS) idx = idx - CHANNELS;
                    if (!w_grantValid && w_chElig[idx]) begin
                        w_grantValid = 1'b1;
                        w_grantSlot  = PTR_W'(idx + 1);
                        w_nextPtr    = (idx + 1 >= CHANNELS) ? '0 : PTR_W'(idx + 1);
                    end
                end
            end
        end else begin
            for (int k = 0; k < NSLOTS; k++) begin
                idx = int'(r_rrPtr) + k;
                if (idx >= NSLOTS) idx = idx - NSLOTS;
                if (!w_grantValid && w_slotElig[idx]) begin
                    w_grantValid = 1'b1;
                    w_grantSlot  = PTR_W'(idx);
                    w_nextPtr    = (idx + 1 >= NSLOTS) ? '0 : PTR_W'(idx + 1);
                end
            end
        end
    end

    // Decode the winner into a CPU flag, a channel one-hot and its address.
    always_comb begin
        w_grantCpu = w_grantValid && (w_grantSlot == '0);
        w_chGrant  = '0;
        w_reqAddr  = bus.CPU_ADDRESS;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grantValid && (w_grantSlot == PTR_W'(i + 1))) begin
                w_chGrant[i] = 1'b1;
                w_reqAddr    = bus.CH_ADDRESS[i*ADDRESS_BITS +: ADDRESS_BITS];
            end
        end
    end

    // On idle cycles the address lines keep their last value.
    assign w_memAddr  = w_grantValid ? w_reqAddr : r_heldAddr;
    assign w_write    = w_grantCpu && bus.CPU_WR;
    assign w_maskWren = {bus.CPU_BYTE_EN[1], bus.CPU_BYTE_EN[1],
                         bus.CPU_BYTE_EN[0], bus.CPU_BYTE_EN[0]};

    generate
        if (ADDRESS_BITS > 14) begin : g_bankDecode
            assign w_bank = w_memAddr[ADDRESS_BITS-1:14];
        end else begin : g_singleBank
            assign w_bank = '0;
        end
    endgenerate

    generate
        for (genvar b = 0; b < BANKS; b++) begin : g_bank
            logic [BITS-1:0] r_mem [0:16383];
            logic [BITS-1:0] r_dataOut;
            logic            w_cs;
            assign w_cs = w_grantValid && (w_bank == BANK_W'(b));

            // SPRAM bank: nibble-masked write or registered read when selected.
            always_ff @(posedge CLK) begin
                if (w_cs) begin
                    if (w_write) begin
                        for (int n = 0; n < 4; n++) begin
                            if (w_maskWren[n]) r_mem[w_memAddr[13:0]][4*n +: 4] <= bus.CPU_DATA_IN[4*n +: 4];
                        end
                    end else begin
                        r_dataOut <= r_mem[w_memAddr[13:0]];
                    end
                end
            end

            assign w_bankOut[b] = r_dataOut;
        end
    endgenerate

    // Register the grant owner (which doubles as READY) and advance the pointer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cpuReady <= 1'b0;
            r_chReady  <= '0;
            r_rrPtr    <= '0;
            r_bank     <= '0;
            r_heldAddr <= '0;
        end else begin
            r_cpuReady <= w_grantCpu;
            r_chReady  <= w_chGrant;
            r_rrPtr    <= w_nextPtr;
            if (w_grantValid) begin
                r_bank     <= w_bank;
                r_heldAddr <= w_memAddr;
            end
        end
    end

    assign bus.CPU_READY    = r_cpuReady;
    assign bus.CH_READY     = r_chReady;
    assign bus.CPU_DATA_OUT = w_bankOut[r_bank];
    assign bus.CH_DATA_OUT  = w_bankOut[r_bank];
endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: stimulus pushes hand-computed expected
// responses into queues, a negedge monitor pops and compares on each READY.
module tb_memory_arbiter;
    localparam int AB = 15;
    localparam int CH = 2;

    typedef struct packed {
        logic        isWrite;
        logic [15:0] data;
    } cpuExp_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    cpuExp_t     cpuQ[$];
    logic [15:0] chQ0[$];
    logic [15:0] chQ1[$];

    memory_arbiter_if #(.BITS(16), .ADDRESS_BITS(AB), .CHANNELS(CH)) bus ();

    memory_arbiter #(.BITS(16), .ADDRESS_BITS(AB), .CHANNELS(CH), .CPU_PRIORITY(1)) dut (
        .CLK (clock),
        .RST (reset),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point; every check goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard whenever a READY pulse is seen.
    always @(negedge clock) begin
        if (!reset) begin
            checkOutput("oneReadyPerCycle", 32'($countones({bus.CPU_READY, bus.CH_READY}) <= 1), 1);
            if (bus.CPU_READY) begin
                checkOutput("cpuRespPending", 32'(cpuQ.size() != 0), 1);
                if (cpuQ.size() != 0) begin
                    cpuExp_t e;
                    e = cpuQ.pop_front();
                    if (!e.isWrite) checkOutput("cpuData", 32'(bus.CPU_DATA_OUT), 32'(e.data));
                end
            end
            if (bus.CH_READY[0]) begin
                checkOutput("ch0RespPending", 32'(chQ0.size() != 0), 1);
                if (chQ0.size() != 0) checkOutput("ch0Data", 32'(bus.CH_DATA_OUT), 32'(chQ0.pop_front()));
            end
            if (bus.CH_READY[1]) begin
                checkOutput("ch1RespPending", 32'(chQ1.size() != 0), 1);
                if (chQ1.size() != 0) checkOutput("ch1Data", 32'(bus.CH_DATA_OUT), 32'(chQ1.pop_front()));
            end
        end
    end

    // One CPU access after an idle cycle; optionally check the 1-cycle latency.
    task automatic cpuAccess(input logic wr, input logic [AB-1:0] addr, input logic [15:0] data,
                             input logic [1:0] be, input logic [15:0] expData, input bit checkLat);
        int      waited;
        bit      seen;
        cpuExp_t e;
        @(negedge clock);
        e.isWrite = wr;
        e.data    = expData;
        cpuQ.push_back(e);
        bus.CPU_ADDRESS = addr;
        bus.CPU_DATA_IN = data;
        bus.CPU_WR      = wr;
        bus.CPU_BYTE_EN = be;
        bus.CPU_VALID   = 1'b1;
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 20) begin
            @(negedge clock);
            waited++;
            if (bus.CPU_READY) seen = 1'b1;
        end
        bus.CPU_VALID = 1'b0;
        if (!seen) begin
            checkOutput("cpuTimeout", 0, 1);
            void'(cpuQ.pop_back());
        end else if (checkLat) begin
            checkOutput("cpuLatency", 32'(waited), 1);
        end
    endtask

    // One channel read after an idle cycle.
    task automatic chRead(input int ch, input logic [AB-1:0] addr, input logic [15:0] expData);
        int waited;
        bit seen;
        @(negedge clock);
        if (ch == 0) chQ0.push_back(expData);
        else         chQ1.push_back(expData);
        bus.CH_ADDRESS[ch*AB +: AB] = addr;
        bus.CH_VALID[ch] = 1'b1;
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 20) begin
            @(negedge clock);
            waited++;
            if (bus.CH_READY[ch]) seen = 1'b1;
        end
        bus.CH_VALID[ch] = 1'b0;
        if (!seen) begin
            checkOutput("chTimeout", 0, 1);
            if (ch == 0) void'(chQ0.pop_back());
            else         void'(chQ1.pop_back());
        end
    endtask

    // Directed sequence covering writes, masking, banking, arbitration and reset.
    task automatic applyStimulus();
        logic [2:0] prioPattern [8];
        prioPattern = '{3'b100, 3'b001, 3'b100, 3'b010, 3'b100, 3'b001, 3'b100, 3'b010};

        cpuAccess(1'b1, 15'h0005, 16'h1234, 2'b11, 16'h0000, 1'b1);
        cpuAccess(1'b0, 15'h0005, 16'h0000, 2'b11, 16'h1234, 1'b1);
        cpuAccess(1'b1, 15'h0005, 16'hAB00, 2'b10, 16'h0000, 1'b1);
        cpuAccess(1'b0, 15'h0005, 16'h0000, 2'b11, 16'hAB34, 1'b1);
        cpuAccess(1'b1, 15'h0010, 16'h1111, 2'b11, 16'h0000, 1'b1);
        cpuAccess(1'b1, 15'h4010, 16'h2222, 2'b11, 16'h0000, 1'b1);
        cpuAccess(1'b0, 15'h0010, 16'h0000, 2'b11, 16'h1111, 1'b1);
        cpuAccess(1'b0, 15'h4010, 16'h0000, 2'b11, 16'h2222, 1'b1);
        cpuAccess(1'b1, 15'h0010, 16'hFFFF, 2'b00, 16'h0000, 1'b1);
        cpuAccess(1'b0, 15'h0010, 16'h0000, 2'b11, 16'h1111, 1'b1);
        chRead(0, 15'h0010, 16'h1111);
        chRead(1, 15'h4010, 16'h2222);

        // Both channels held, CPU idle: grants alternate ch0, ch1, ...
        @(negedge clock);
        bus.CH_ADDRESS = {15'h4010, 15'h0010};
        for (int i = 0; i < 4; i++) begin
            chQ0.push_back(16'h1111);
            chQ1.push_back(16'h2222);
        end
        bus.CH_VALID = 2'b11;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            checkOutput("chAlternate", 32'({bus.CPU_READY, bus.CH_READY}), (c % 2 == 0) ? 32'b001 : 32'b010);
        end
        bus.CH_VALID = 2'b00;

        // CPU and both channels held: CPU every other cycle, channels share gaps.
        @(negedge clock);
        bus.CPU_ADDRESS = 15'h0005;
        bus.CPU_WR      = 1'b0;
        bus.CPU_VALID   = 1'b1;
        bus.CH_VALID    = 2'b11;
        for (int i = 0; i < 4; i++) begin
            cpuQ.push_back(cpuExp_t'({1'b0, 16'hAB34}));
        end
        for (int i = 0; i < 2; i++) begin
            chQ0.push_back(16'h1111);
            chQ1.push_back(16'h2222);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            checkOutput("cpuPriority", 32'({bus.CPU_READY, bus.CH_READY}), 32'(prioPattern[c]));
        end
        bus.CPU_VALID = 1'b0;
        bus.CH_VALID  = 2'b00;

        // Same-address CPU write and channel read: channel sees new data.
        fork
            cpuAccess(1'b1, 15'h0020, 16'h5A5A, 2'b11, 16'h0000, 1'b1);
            chRead(0, 15'h0020, 16'h5A5A);
        join
        cpuAccess(1'b0, 15'h0020, 16'h0000, 2'b11, 16'h5A5A, 1'b1);

        // Reset in the cycle after a CPU read grant: the READY is lost.
        @(negedge clock);
        bus.CPU_ADDRESS = 15'h0005;
        bus.CPU_WR      = 1'b0;
        bus.CPU_VALID   = 1'b1;
        @(posedge clock);
        #1;
        reset         = 1'b1;
        bus.CPU_VALID = 1'b0;
        @(negedge clock);
        checkOutput("rstCpuReady", 32'(bus.CPU_READY), 0);
        checkOutput("rstChReady", 32'(bus.CH_READY), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("postRstCpuReady", 32'(bus.CPU_READY), 0);
        checkOutput("postRstChReady", 32'(bus.CH_READY), 0);
        cpuAccess(1'b0, 15'h0005, 16'h0000, 2'b11, 16'hAB34, 1'b1);
        chRead(0, 15'h0010, 16'h1111);
        cpuAccess(1'b0, 15'h4010, 16'h0000, 2'b11, 16'h2222, 1'b1);
        repeat (2) @(negedge clock);
    endtask

    // Main sequence: reset, run stimulus, drain and summarise.
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.CPU_ADDRESS = '0;
        bus.CPU_DATA_IN = '0;
        bus.CPU_WR      = 1'b0;
        bus.CPU_BYTE_EN = 2'b00;
        bus.CPU_VALID   = 1'b0;
        bus.CH_ADDRESS  = '0;
        bus.CH_VALID    = '0;
        repeat (3) @(negedge clock);
        checkOutput("resetCpuReady", 32'(bus.CPU_READY), 0);
        checkOutput("resetChReady", 32'(bus.CH_READY), 0);
        reset = 1'b0;
        applyStimulus();
        checkOutput("cpuQueueDrained", 32'(cpuQ.size()), 0);
        checkOutput("ch0QueueDrained", 32'(chQ0.size()), 0);
        checkOutput("ch1QueueDrained", 32'(chQ1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
